// File: rtl/idli_dcd_collect_m.sv
// Serial instruction collector / pre-decoder: assembles INSN_W-bit instructions from
// DATA_W-bit MSB-first beats and classifies the major opcode into a held output register.
module idli_dcd_collect_m #(
    parameter int unsigned DATA_W = 4,
    parameter int unsigned INSN_W = 16
) (
    input  logic              i_dcd_gck,
    input  logic              i_dcd_rst_n,
    input  logic [DATA_W-1:0] i_dcd_enc,
    input  logic              i_dcd_enc_vld,
    output logic              o_dcd_enc_rdy,
    input  logic              i_dcd_flush,
    output logic              o_dcd_vld,
    input  logic              i_dcd_rdy,
    output logic [INSN_W-1:0] o_dcd_insn,
    output logic [2:0]        o_dcd_cls,
    output logic              o_dcd_ill,
    output logic              o_dcd_busy
);

    localparam int unsigned BEATS = INSN_W / DATA_W;
    localparam int unsigned CW    = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [CW-1:0] LAST_BEAT = CW'(BEATS - 1);

    typedef enum logic {
        S_IDLE,
        S_COLLECT
    } state_t;

    typedef enum logic [2:0] {
        CLS_NOP_BZ = 3'd0,
        CLS_CMP    = 3'd1,
        CLS_SHIFT  = 3'd2,
        CLS_MEM    = 3'd3,
        CLS_MISC   = 3'd4,
        CLS_ALU    = 3'd5,
        CLS_MOVBR  = 3'd6,
        CLS_ILL    = 3'd7
    } cls_t;

    state_t                r_state;
    logic [CW-1:0]         r_cnt;
    logic [INSN_W-1:0]     r_shift;
    logic                  r_vld;
    logic [INSN_W-1:0]     r_insn;
    cls_t                  r_cls;
    logic                  r_ill;

    logic                  w_last;
    logic                  w_enc_rdy;
    logic                  w_accept;
    logic                  w_load;
    logic [INSN_W+DATA_W-1:0] w_cat;
    logic [INSN_W-1:0]     w_next_shift;
    logic [3:0]            w_opc;
    cls_t                  w_cls;
    logic                  w_ill;

    assign w_last = (r_cnt == LAST_BEAT);

    // Only the final beat needs the output register free; a consumer taking the
    // pending instruction this cycle frees it in time, hence the i_dcd_rdy term.
    assign w_enc_rdy = !(w_last && r_vld && !i_dcd_rdy) && !i_dcd_flush;
    assign w_accept  = i_dcd_enc_vld && w_enc_rdy;
    assign w_load    = w_accept && w_last;

    assign w_cat        = {r_shift, i_dcd_enc};
    assign w_next_shift = w_cat[INSN_W-1:0];
    assign w_opc        = w_next_shift[INSN_W-1 -: 4];

    always_comb begin
        w_cls = CLS_NOP_BZ;
        w_ill = 1'b0;
        case (w_opc)
            4'b0000:                   w_cls = CLS_NOP_BZ;
            4'b0001, 4'b0010, 4'b0011: begin
                w_cls = CLS_ILL;
                w_ill = 1'b1;
            end
            4'b0100, 4'b0101:          w_cls = CLS_CMP;
            4'b0110, 4'b0111:          w_cls = CLS_SHIFT;
            4'b1000, 4'b1001, 4'b1010: w_cls = CLS_MEM;
            4'b1011:                   w_cls = CLS_MISC;
            4'b1100, 4'b1101, 4'b1110: w_cls = CLS_ALU;
            4'b1111:                   w_cls = CLS_MOVBR;
            default:                   w_cls = CLS_NOP_BZ;
        endcase
    end

    always_ff @(posedge i_dcd_gck or negedge i_dcd_rst_n) begin
        if (!i_dcd_rst_n) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_shift <= '0;
            r_vld   <= 1'b0;
            r_insn  <= '0;
            r_cls   <= CLS_NOP_BZ;
            r_ill   <= 1'b0;
        end else if (i_dcd_flush) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_vld   <= 1'b0;
        end else begin
            if (w_accept) begin
                r_shift <= w_next_shift;
                if (w_last) begin
                    r_cnt   <= '0;
                    r_state <= S_IDLE;
                end else begin
                    r_cnt   <= r_cnt + CW'(1);
                    r_state <= S_COLLECT;
                end
            end
            if (w_load) begin
                r_vld  <= 1'b1;
                r_insn <= w_next_shift;
                r_cls  <= w_cls;
                r_ill  <= w_ill;
            end else if (r_vld && i_dcd_rdy) begin
                r_vld <= 1'b0;
            end
        end
    end

    assign o_dcd_enc_rdy = w_enc_rdy;
    assign o_dcd_vld     = r_vld;
    assign o_dcd_insn    = r_insn;
    assign o_dcd_cls     = r_cls;
    assign o_dcd_ill     = r_ill;
    assign o_dcd_busy    = (r_state == S_COLLECT);

endmodule

// File: tb/tb_idli_dcd_collect_m.sv
// Directed bench for idli_dcd_collect_m: opcode-class table plus handshake, flush,
// width-variant and async-reset sequences.
module tb_idli_dcd_collect_m;

    logic        clk;
    logic        rst_n;

    logic [3:0]  enc;
    logic        enc_vld, enc_rdy, flush, vld, rdy, ill, busy;
    logic [15:0] insn;
    logic [2:0]  cls;

    logic [7:0]  enc8;
    logic        enc_vld8, enc_rdy8, flush8, vld8, rdy8, ill8, busy8;
    logic [15:0] insn8;
    logic [2:0]  cls8;

    logic        enc1;
    logic        enc_vld1, enc_rdy1, flush1, vld1, rdy1, ill1, busy1;
    logic [15:0] insn1;
    logic [2:0]  cls1;

    int total = 0;
    int bad   = 0;

    idli_dcd_collect_m #(.DATA_W(4), .INSN_W(16)) dut (
        .i_dcd_gck(clk), .i_dcd_rst_n(rst_n),
        .i_dcd_enc(enc), .i_dcd_enc_vld(enc_vld), .o_dcd_enc_rdy(enc_rdy),
        .i_dcd_flush(flush), .o_dcd_vld(vld), .i_dcd_rdy(rdy),
        .o_dcd_insn(insn), .o_dcd_cls(cls), .o_dcd_ill(ill), .o_dcd_busy(busy)
    );

    idli_dcd_collect_m #(.DATA_W(8), .INSN_W(16)) dut8 (
        .i_dcd_gck(clk), .i_dcd_rst_n(rst_n),
        .i_dcd_enc(enc8), .i_dcd_enc_vld(enc_vld8), .o_dcd_enc_rdy(enc_rdy8),
        .i_dcd_flush(flush8), .o_dcd_vld(vld8), .i_dcd_rdy(rdy8),
        .o_dcd_insn(insn8), .o_dcd_cls(cls8), .o_dcd_ill(ill8), .o_dcd_busy(busy8)
    );

    idli_dcd_collect_m #(.DATA_W(1), .INSN_W(16)) dut1 (
        .i_dcd_gck(clk), .i_dcd_rst_n(rst_n),
        .i_dcd_enc(enc1), .i_dcd_enc_vld(enc_vld1), .o_dcd_enc_rdy(enc_rdy1),
        .i_dcd_flush(flush1), .o_dcd_vld(vld1), .i_dcd_rdy(rdy1),
        .o_dcd_insn(insn1), .o_dcd_cls(cls1), .o_dcd_ill(ill1), .o_dcd_busy(busy1)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic [15:0] insn;
        logic [2:0]  cls;
        logic        ill;
    } vec_t;

    vec_t vecs[16];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Present one beat on the 4-bit instance; it must be accepted at the next edge.
    task automatic beat(input logic [3:0] b);
        enc     = b;
        enc_vld = 1'b1;
        #1;
        chk("enc_rdy", {31'b0, enc_rdy}, 32'd1);
        tick;
    endtask

    initial begin
        vecs[0]  = '{16'hC123, 3'd5, 1'b0};
        vecs[1]  = '{16'h1FFF, 3'd7, 1'b1};
        vecs[2]  = '{16'h0000, 3'd0, 1'b0};
        vecs[3]  = '{16'h2ABC, 3'd7, 1'b1};
        vecs[4]  = '{16'h3001, 3'd7, 1'b1};
        vecs[5]  = '{16'h4567, 3'd1, 1'b0};
        vecs[6]  = '{16'h5000, 3'd1, 1'b0};
        vecs[7]  = '{16'h6789, 3'd2, 1'b0};
        vecs[8]  = '{16'h7FFE, 3'd2, 1'b0};
        vecs[9]  = '{16'h8123, 3'd3, 1'b0};
        vecs[10] = '{16'h9ABC, 3'd3, 1'b0};
        vecs[11] = '{16'hA5A5, 3'd3, 1'b0};
        vecs[12] = '{16'hB000, 3'd4, 1'b0};
        vecs[13] = '{16'hD00D, 3'd5, 1'b0};
        vecs[14] = '{16'hEEEE, 3'd5, 1'b0};
        vecs[15] = '{16'hF00F, 3'd6, 1'b0};

        rst_n = 1'b0;
        enc = '0;  enc_vld = 1'b0;  flush = 1'b0;  rdy = 1'b0;
        enc8 = '0; enc_vld8 = 1'b0; flush8 = 1'b0; rdy8 = 1'b0;
        enc1 = '0; enc_vld1 = 1'b0; flush1 = 1'b0; rdy1 = 1'b0;
        #12;
        chk("rst_vld",  {31'b0, vld}, 32'd0);
        chk("rst_insn", {16'b0, insn}, 32'd0);
        chk("rst_cls",  {29'b0, cls}, 32'd0);
        chk("rst_ill",  {31'b0, ill}, 32'd0);
        chk("rst_busy", {31'b0, busy}, 32'd0);
        chk("rst_vld8", {31'b0, vld8}, 32'd0);
        chk("rst_vld1", {31'b0, vld1}, 32'd0);
        rst_n = 1'b1;
        tick;

        // Class table, consumer always ready
        rdy = 1'b1;
        for (int i = 0; i < 16; i++) begin
            for (int k = 0; k < 4; k++) begin
                beat(vecs[i].insn[15-4*k -: 4]);
                if (k == 1) chk("tbl_busy_mid", {31'b0, busy}, 32'd1);
                if (k < 3)  chk("tbl_vld_early", {31'b0, vld}, 32'd0);
            end
            enc_vld = 1'b0;
            chk("tbl_vld",  {31'b0, vld}, 32'd1);
            chk("tbl_insn", {16'b0, insn}, {16'b0, vecs[i].insn});
            chk("tbl_cls",  {29'b0, cls}, {29'b0, vecs[i].cls});
            chk("tbl_ill",  {31'b0, ill}, {31'b0, vecs[i].ill});
            chk("tbl_busy_end", {31'b0, busy}, 32'd0);
            tick;
            chk("tbl_consumed", {31'b0, vld}, 32'd0);
        end

        // Back-to-back: second insn replaces the first while it is consumed on the final beat
        rdy = 1'b1;
        beat(4'hC); beat(4'h1); beat(4'h2); beat(4'h3);
        chk("b2b_vld0",  {31'b0, vld}, 32'd1);
        chk("b2b_insn0", {16'b0, insn}, 32'hC123);
        rdy = 1'b0;
        beat(4'h4);
        chk("b2b_hold_vld",  {31'b0, vld}, 32'd1);
        chk("b2b_hold_insn", {16'b0, insn}, 32'hC123);
        beat(4'h5); beat(4'h6);
        chk("b2b_hold_insn2", {16'b0, insn}, 32'hC123);
        rdy = 1'b1;
        beat(4'h7);
        chk("b2b_vld1",  {31'b0, vld}, 32'd1);
        chk("b2b_insn1", {16'b0, insn}, 32'h4567);
        chk("b2b_cls1",  {29'b0, cls}, 32'd1);

        // Stall: final beat of third insn waits for the consumer
        rdy = 1'b0;
        beat(4'h8); beat(4'h9); beat(4'hA);
        enc     = 4'hB;
        enc_vld = 1'b1;
        repeat (2) begin
            #1;
            chk("stall_enc_rdy", {31'b0, enc_rdy}, 32'd0);
            tick;
            chk("stall_insn", {16'b0, insn}, 32'h4567);
            chk("stall_busy", {31'b0, busy}, 32'd1);
        end
        rdy = 1'b1;
        #1;
        chk("unstall_enc_rdy", {31'b0, enc_rdy}, 32'd1);
        tick;
        enc_vld = 1'b0;
        chk("unstall_vld",  {31'b0, vld}, 32'd1);
        chk("unstall_insn", {16'b0, insn}, 32'h89AB);
        tick;
        chk("unstall_consumed", {31'b0, vld}, 32'd0);

        // Flush with a pending output and a partial A5xx; the flush-cycle beat is dropped
        rdy = 1'b0;
        beat(4'h1); beat(4'h2); beat(4'h3); beat(4'h4);
        chk("fl_pending", {31'b0, vld}, 32'd1);
        beat(4'hA); beat(4'h5);
        enc     = 4'h7;
        enc_vld = 1'b1;
        flush   = 1'b1;
        #1;
        chk("fl_enc_rdy", {31'b0, enc_rdy}, 32'd0);
        tick;
        flush = 1'b0;
        chk("fl_vld",  {31'b0, vld}, 32'd0);
        chk("fl_busy", {31'b0, busy}, 32'd0);
        beat(4'hF); beat(4'h0); beat(4'h1);
        chk("fl_no_early", {31'b0, vld}, 32'd0);
        beat(4'h2);
        enc_vld = 1'b0;
        chk("fl_vld_new", {31'b0, vld}, 32'd1);
        chk("fl_insn",    {16'b0, insn}, 32'hF012);
        chk("fl_cls",     {29'b0, cls}, 32'd6);
        chk("fl_ill",     {31'b0, ill}, 32'd0);
        rdy = 1'b1;
        tick;
        chk("fl_consumed", {31'b0, vld}, 32'd0);

        // DATA_W=8
        rdy8 = 1'b1;
        enc8 = 8'hB4; enc_vld8 = 1'b1;
        tick;
        chk("w8_busy", {31'b0, busy8}, 32'd1);
        enc8 = 8'h21;
        tick;
        enc_vld8 = 1'b0;
        chk("w8_vld",  {31'b0, vld8}, 32'd1);
        chk("w8_insn", {16'b0, insn8}, 32'hB421);
        chk("w8_cls",  {29'b0, cls8}, 32'd4);
        chk("w8_ill",  {31'b0, ill8}, 32'd0);

        // DATA_W=1
        begin
            logic [15:0] w;
            w = 16'h6A3C;
            rdy1 = 1'b1;
            enc_vld1 = 1'b1;
            for (int i = 15; i >= 0; i--) begin
                enc1 = w[i];
                tick;
                if (i == 8) chk("w1_no_early", {31'b0, vld1}, 32'd0);
            end
            enc_vld1 = 1'b0;
            chk("w1_vld",  {31'b0, vld1}, 32'd1);
            chk("w1_insn", {16'b0, insn1}, 32'h6A3C);
            chk("w1_cls",  {29'b0, cls1}, 32'd2);
            chk("w1_busy", {31'b0, busy1}, 32'd0);
        end

        // Async reset with a pending output and three partial beats
        rdy = 1'b0;
        beat(4'h1); beat(4'h2); beat(4'h3); beat(4'h4);
        beat(4'h9); beat(4'h8); beat(4'h7);
        chk("ar_pre_vld",  {31'b0, vld}, 32'd1);
        chk("ar_pre_busy", {31'b0, busy}, 32'd1);
        enc_vld = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        chk("ar_vld",  {31'b0, vld}, 32'd0);
        chk("ar_insn", {16'b0, insn}, 32'd0);
        chk("ar_cls",  {29'b0, cls}, 32'd0);
        chk("ar_ill",  {31'b0, ill}, 32'd0);
        chk("ar_busy", {31'b0, busy}, 32'd0);
        tick;
        rst_n = 1'b1;
        tick;
        beat(4'h5); beat(4'hA); beat(4'hB);
        chk("ar_no_early", {31'b0, vld}, 32'd0);
        beat(4'hC);
        enc_vld = 1'b0;
        chk("ar_new_vld",  {31'b0, vld}, 32'd1);
        chk("ar_new_insn", {16'b0, insn}, 32'h5ABC);
        chk("ar_new_cls",  {29'b0, cls}, 32'd1);
        rdy = 1'b1;
        tick;
        chk("ar_consumed", {31'b0, vld}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
